// File: rtl/mmio_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_bus_ctrl_if
//  Purpose  : Core-side request/response bus of the memory-mapped controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface mmio_bus_ctrl_if;
    logic        req_in;
    logic        we_in;
    logic [31:0] addr_in;
    logic [31:0] wr_data_in;
    logic [3:0]  be_in;
    logic        ready_out;
    logic        resp_valid_out;
    logic [31:0] rd_data_out;
    logic        err_out;

    modport master (
        output req_in, we_in, addr_in, wr_data_in, be_in,
        input  ready_out, resp_valid_out, rd_data_out, err_out
    );

    modport slave (
        input  req_in, we_in, addr_in, wr_data_in, be_in,
        output ready_out, resp_valid_out, rd_data_out, err_out
    );
endinterface
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_bus_ctrl
//  Purpose  : Memory-mapped bus controller: external ROM port, scratch RAM,
//             switch/LED/seven-segment IO, optional cycle timer
//             (MMIO_BUS_CTRL_TIMER_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_ctrl #(
    parameter logic [31:0] INSTR_BASE    = 32'h0000_0000,
    parameter int          INSTR_WORDS   = 1024,
    parameter logic [31:0] SCRATCH_BASE  = 32'h0001_0000,
    parameter int          SCRATCH_WORDS = 256,
    parameter logic [31:0] IO_BASE       = 32'h0002_0000,
    parameter int          NUM_GPIO      = 2,
    parameter int          WAIT_STATES   = 0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    mmio_bus_ctrl_if.slave                 bus,
    output logic [$clog2(INSTR_WORDS)-1:0] rom_addr_out,
    input  logic [31:0]                    rom_data_in,
    input  logic [16*NUM_GPIO-1:0]         sw_in,
    output logic [16*NUM_GPIO-1:0]         led_out,
    output logic [31:0]                    sseg_data_out
);

    localparam int          c_RA_W      = $clog2(INSTR_WORDS);
    localparam int          c_SA_W      = $clog2(SCRATCH_WORDS);
    localparam logic [31:0] c_ROM_BYTES = 32'(4 * INSTR_WORDS);
    localparam logic [31:0] c_SCR_BYTES = 32'(4 * SCRATCH_WORDS);
    localparam logic [31:0] c_GPIO_SPAN = 32'(4 * NUM_GPIO);
    localparam logic [31:0] c_LED_OFF   = 32'h40;
    localparam logic [31:0] c_SSEG_OFF  = 32'h80;
    localparam logic [3:0]  c_WAIT_INIT = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]          r_state, w_state_nxt;
    logic                w_ready, w_resp;
    logic [3:0]          r_wait_cnt;
    logic [c_RA_W-1:0]   r_rom_word;
    logic [31:0]         r_rd_data;
    logic                r_err;
    logic                r_rom_pend;
    logic [16*NUM_GPIO-1:0] r_sw_meta, r_sw_sync;
    logic [15:0]         r_led [NUM_GPIO];
    logic [31:0]         r_sseg;
    logic [31:0]         r_ram [SCRATCH_WORDS];

    logic [31:0] w_rom_off, w_scr_off, w_io_off;
    logic [3:0]  w_io_idx;
    logic [c_SA_W-1:0] w_scr_idx;
    logic w_hit_rom, w_hit_scr, w_hit_sw, w_hit_led, w_hit_sseg, w_hit_timer;
    logic w_err, w_accept, w_wr_ok;
    logic [31:0] w_rd_val, w_timer_rd;
    logic [15:0] w_sw_val, w_led_val;

    // Address decode is done on the live request so it is ready at the accept edge
    assign w_rom_off  = bus.addr_in - INSTR_BASE;
    assign w_scr_off  = bus.addr_in - SCRATCH_BASE;
    assign w_io_off   = bus.addr_in - IO_BASE;
    assign w_io_idx   = w_io_off[5:2];
    assign w_scr_idx  = w_scr_off[c_SA_W+1:2];
    assign w_hit_rom  = w_rom_off < c_ROM_BYTES;
    assign w_hit_scr  = w_scr_off < c_SCR_BYTES;
    assign w_hit_sw   = w_io_off < c_GPIO_SPAN;
    assign w_hit_led  = (w_io_off >= c_LED_OFF) && (w_io_off < c_LED_OFF + c_GPIO_SPAN);
    assign w_hit_sseg = w_io_off == c_SSEG_OFF;

    assign w_err = (|bus.addr_in[1:0])
                 | ~(w_hit_rom | w_hit_scr | w_hit_sw | w_hit_led | w_hit_sseg | w_hit_timer)
                 | (bus.we_in & (w_hit_rom | w_hit_sw));
    assign w_accept = (r_state == c_ST_IDLE) && bus.req_in;
    assign w_wr_ok  = w_accept && bus.we_in && !w_err;

`ifdef MMIO_BUS_CTRL_TIMER_EN
    logic [31:0] r_timer;

    assign w_hit_timer = w_io_off == 32'h84;
    // A read sees the value the counter takes at the accept edge
    assign w_timer_rd  = r_timer + 32'd1;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_timer <= '0;
        end else if (w_wr_ok && w_hit_timer) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_in[k]) r_timer[8*k +: 8] <= bus.wr_data_in[8*k +: 8];
            end
        end else begin
            r_timer <= w_timer_rd;
        end
    end
`else
    assign w_hit_timer = 1'b0;
    assign w_timer_rd  = '0;
`endif

    always_comb begin
        w_sw_val  = '0;
        w_led_val = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (w_io_idx == 4'(i)) begin
                w_sw_val  = r_sw_sync[16*i +: 16];
                w_led_val = r_led[i];
            end
        end
        w_rd_val = '0;
        if (w_hit_scr)        w_rd_val = r_ram[w_scr_idx];
        else if (w_hit_sw)    w_rd_val = {16'd0, w_sw_val};
        else if (w_hit_led)   w_rd_val = {16'd0, w_led_val};
        else if (w_hit_sseg)  w_rd_val = r_sseg;
        else if (w_hit_timer) w_rd_val = w_timer_rd;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_resp      = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_in) w_state_nxt = (WAIT_STATES > 0) ? c_ST_WAIT : c_ST_RESP;
            end
            c_ST_WAIT: if (r_wait_cnt == 4'd0) w_state_nxt = c_ST_RESP;
            c_ST_RESP: begin
                w_resp      = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wait_cnt <= '0;
            r_rom_word <= '0;
            r_rd_data  <= '0;
            r_err      <= 1'b0;
            r_rom_pend <= 1'b0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_sseg     <= '0;
            for (int i = 0; i < NUM_GPIO; i++) r_led[i] <= '0;
        end else begin
            r_sw_meta <= sw_in;
            r_sw_sync <= r_sw_meta;
            // ROM output is valid the cycle after the address was presented
            if (r_rom_pend) begin
                r_rd_data  <= rom_data_in;
                r_rom_pend <= 1'b0;
            end
            if (w_accept) begin
                r_rom_word <= bus.addr_in[c_RA_W+1:2];
                r_err      <= w_err;
                r_rd_data  <= (bus.we_in || w_err) ? 32'd0 : w_rd_val;
                r_rom_pend <= !bus.we_in && !w_err && w_hit_rom;
                r_wait_cnt <= c_WAIT_INIT;
            end else if ((r_state == c_ST_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_wr_ok && w_hit_sseg) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.be_in[k]) r_sseg[8*k +: 8] <= bus.wr_data_in[8*k +: 8];
                end
            end
            if (w_wr_ok && w_hit_led) begin
                for (int i = 0; i < NUM_GPIO; i++) begin
                    if (w_io_idx == 4'(i)) begin
                        if (bus.be_in[0]) r_led[i][7:0]  <= bus.wr_data_in[7:0];
                        if (bus.be_in[1]) r_led[i][15:8] <= bus.wr_data_in[15:8];
                    end
                end
            end
        end
    end

    // Scratch contents are intentionally not reset
    always_ff @(posedge clk_in) begin
        if (w_wr_ok && w_hit_scr) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.be_in[k]) r_ram[w_scr_idx][8*k +: 8] <= bus.wr_data_in[8*k +: 8];
            end
        end
    end

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_led_out
        assign led_out[16*g +: 16] = r_led[g];
    end

    assign bus.ready_out      = w_ready && !rst_in;
    assign bus.resp_valid_out = w_resp;
    assign bus.err_out        = w_resp && r_err;
    assign bus.rd_data_out    = !w_resp ? 32'd0 : (r_rom_pend ? rom_data_in : r_rd_data);
    assign rom_addr_out       = (r_state == c_ST_IDLE) ? bus.addr_in[c_RA_W+1:2] : r_rom_word;
    assign sseg_data_out      = r_sseg;

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_bus_ctrl
//  Purpose  : Self-checking bench for mmio_bus_ctrl (zero and three wait states).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_ctrl;

    localparam logic [31:0] c_SCR = 32'h0001_0000;
    localparam logic [31:0] c_IO  = 32'h0002_0000;
    localparam int          c_NG  = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    mmio_bus_ctrl_if bus0 ();
    mmio_bus_ctrl_if bus3 ();

    logic [9:0]         rom_addr0, rom_addr3;
    logic [31:0]        rom_data0, rom_data3;
    logic [16*c_NG-1:0] sw;
    logic [16*c_NG-1:0] led0, led3;
    logic [31:0]        sseg0, sseg3;

    mmio_bus_ctrl #(.WAIT_STATES(0)) u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus0),
        .rom_addr_out(rom_addr0), .rom_data_in(rom_data0),
        .sw_in(sw), .led_out(led0), .sseg_data_out(sseg0)
    );

    mmio_bus_ctrl #(.WAIT_STATES(3)) u_dut3 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus3),
        .rom_addr_out(rom_addr3), .rom_data_in(rom_data3),
        .sw_in(sw), .led_out(led3), .sseg_data_out(sseg3)
    );

    function automatic logic [31:0] rom_fn(input logic [9:0] w);
        return (w == 10'd2) ? 32'hDEAD_BEEF : ({22'd0, w} * 32'h9E37_79B9);
    endfunction

    // Synchronous ROM model
    always @(posedge clk_in) begin
        rom_data0 <= rom_fn(rom_addr0);
        rom_data3 <= rom_fn(rom_addr3);
    end

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        return r;
    endfunction

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_scr [16];
    logic [15:0] m_led [c_NG];
    logic [31:0] m_sseg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xact0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, output logic [31:0] rd, output logic err,
                         output int lat);
        int guard;
        @(negedge clk_in);
        guard = 0;
        while (!bus0.ready_out && guard < 20) begin
            @(negedge clk_in);
            guard++;
        end
        check("ready_idle", {31'd0, bus0.ready_out}, 32'd1);
        check("rd_zero_idle", bus0.rd_data_out, 32'd0);
        bus0.req_in     = 1'b1;
        bus0.we_in      = we;
        bus0.addr_in    = addr;
        bus0.wr_data_in = wd;
        bus0.be_in      = be;
        @(posedge clk_in);
        #1;
        bus0.req_in = 1'b0;
        bus0.we_in  = 1'b0;
        bus0.be_in  = 4'h0;
        rd  = 'x;
        err = 1'bx;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk_in);
            lat++;
            if (bus0.resp_valid_out) begin
                rd  = bus0.rd_data_out;
                err = bus0.err_out;
                break;
            end
        end
    endtask

    task automatic do0(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be, input logic chk_rd,
                       input logic [31:0] e_rd, input logic e_err);
        logic [31:0] rd;
        logic        err;
        int          lat;
        xact0(we, addr, wd, be, rd, err, lat);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
        if (chk_rd) check({tag, "_rd"}, rd, e_rd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] addr, wd, e_rd;
        logic [3:0]  be;
        logic        we, e_err;
        logic [9:0]  w10;
        int          cat, idx, ch;

        bus0.req_in = 1'b0; bus0.we_in = 1'b0; bus0.addr_in = '0; bus0.wr_data_in = '0; bus0.be_in = '0;
        bus3.req_in = 1'b0; bus3.we_in = 1'b0; bus3.addr_in = '0; bus3.wr_data_in = '0; bus3.be_in = '0;
        sw     = $urandom;
        m_sseg = '0;
        for (int i = 0; i < c_NG; i++) m_led[i] = '0;

        // Reset state
        repeat (3) @(negedge clk_in);
        check("rst_ready0", {31'd0, bus0.ready_out}, 32'd0);
        check("rst_ready3", {31'd0, bus3.ready_out}, 32'd0);
        check("rst_resp0", {31'd0, bus0.resp_valid_out}, 32'd0);
        check("rst_err0", {31'd0, bus0.err_out}, 32'd0);
        check("rst_rd0", bus0.rd_data_out, 32'd0);
        check("rst_led0", led0, 32'd0);
        check("rst_sseg0", sseg0, 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("post_rst_ready0", {31'd0, bus0.ready_out}, 32'd1);
        check("post_rst_ready3", {31'd0, bus3.ready_out}, 32'd1);

        // ROM read through the external synchronous port
        do0("rom_read", 1'b0, 32'h0000_0008, 32'd0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Scratch RAM fill, byte-enable merge, no-op write
        for (int i = 0; i < 16; i++) begin
            m_scr[i] = $urandom;
            do0("scr_fill", 1'b1, c_SCR + 32'(4*i), m_scr[i], 4'hF, 1'b0, 32'd0, 1'b0);
        end
        do0("scr_pre", 1'b1, c_SCR + 32'd4, 32'hAAAA_AAAA, 4'hF, 1'b0, 32'd0, 1'b0);
        do0("scr_be", 1'b1, c_SCR + 32'd4, 32'h1122_3344, 4'b0101, 1'b0, 32'd0, 1'b0);
        do0("scr_rb", 1'b0, c_SCR + 32'd4, 32'd0, 4'h0, 1'b1, 32'hAA22_AA44, 1'b0);
        do0("scr_be0", 1'b1, c_SCR + 32'd4, 32'h5555_5555, 4'h0, 1'b0, 32'd0, 1'b0);
        do0("scr_be0_rb", 1'b0, c_SCR + 32'd4, 32'd0, 4'h0, 1'b1, 32'hAA22_AA44, 1'b0);
        m_scr[1] = 32'hAA22_AA44;

        // LED channel 1 takes lanes 0-1 only
        do0("led_wr", 1'b1, c_IO + 32'h44, 32'hFFFF_1234, 4'hF, 1'b0, 32'd0, 1'b0);
        m_led[1] = 16'h1234;
        check("led_out_ch1", {16'd0, led0[31:16]}, 32'h0000_1234);
        do0("led_rd", 1'b0, c_IO + 32'h44, 32'd0, 4'h0, 1'b1, 32'h0000_1234, 1'b0);

        // Illegal accesses leave all state untouched
        do0("err_misalign", 1'b0, c_SCR + 32'd2, 32'd0, 4'h0, 1'b1, 32'd0, 1'b1);
        do0("err_mis_wr", 1'b1, c_SCR + 32'd6, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b1);
        do0("err_sw_wr", 1'b1, c_IO, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b1);
        do0("err_unmapped", 1'b0, 32'h0003_0000, 32'd0, 4'h0, 1'b1, 32'd0, 1'b1);
        do0("err_rom_wr", 1'b1, 32'h0000_0010, 32'h1, 4'hF, 1'b1, 32'd0, 1'b1);
        do0("err_led_mis", 1'b1, c_IO + 32'h41, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'd0, 1'b1);
        do0("err_after_rb", 1'b0, c_SCR + 32'd4, 32'd0, 4'h0, 1'b1, 32'hAA22_AA44, 1'b0);
        check("err_led_kept", led0, {m_led[1], m_led[0]});

        // Timer at IO_BASE+0x84
`ifdef MMIO_BUS_CTRL_TIMER_EN
        do0("timer_wr", 1'b1, c_IO + 32'h84, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'd0, 1'b0);
        do0("timer_rd", 1'b0, c_IO + 32'h84, 32'd0, 4'h0, 1'b1, 32'd0, 1'b0);
`else
        do0("timer_absent", 1'b1, c_IO + 32'h84, 32'hFFFF_FFFE, 4'hF, 1'b1, 32'd0, 1'b1);
`endif

        // Randomised traffic against the reference model
        for (int t = 0; t < 150; t++) begin
            cat   = $urandom_range(0, 8);
            we    = 1'($urandom_range(0, 1));
            wd    = $urandom;
            be    = 4'($urandom_range(0, 15));
            e_rd  = 32'd0;
            e_err = 1'b1;
            idx   = $urandom_range(0, 15);
            ch    = $urandom_range(0, c_NG - 1);
            case (cat)
                0: begin
                    w10   = 10'($urandom_range(0, 1023));
                    addr  = {20'd0, w10, 2'b00};
                    e_err = we;
                    if (!we) e_rd = rom_fn(w10);
                end
                1: begin
                    addr  = c_SCR + 32'(4*idx);
                    e_err = 1'b0;
                    if (we) m_scr[idx] = merge(m_scr[idx], wd, be);
                    else    e_rd = m_scr[idx];
                end
                2: begin
                    addr  = c_IO + 32'(4*ch);
                    e_err = we;
                    if (!we) e_rd = {16'd0, sw[16*ch +: 16]};
                end
                3: begin
                    addr  = c_IO + 32'h40 + 32'(4*ch);
                    e_err = 1'b0;
                    if (we) m_led[ch] = merge({16'd0, m_led[ch]}, wd, be & 4'b0011) % 32'h1_0000;
                    else    e_rd = {16'd0, m_led[ch]};
                end
                4: begin
                    addr  = c_IO + 32'h80;
                    e_err = 1'b0;
                    if (we) m_sseg = merge(m_sseg, wd, be);
                    else    e_rd = m_sseg;
                end
                5: addr = c_SCR + 32'(4*idx) + 32'($urandom_range(1, 3));
                6: addr = 32'h0003_0000 + 32'(4*idx);
                7: addr = c_IO + 32'(4*(c_NG + $urandom_range(0, 5)));
                default: addr = c_SCR + 32'h400 + 32'(4*idx);
            endcase
            do0("rand", we, addr, wd, be, !we || e_err, e_rd, e_err);
            check("rand_led", led0, {m_led[1], m_led[0]});
            check("rand_sseg", sseg0, m_sseg);
        end

        // Back-to-back requests with three wait states: period of five cycles
        @(negedge clk_in);
        bus3.req_in  = 1'b1;
        bus3.we_in   = 1'b1;
        bus3.addr_in = c_IO + 32'h80;
        bus3.be_in   = 4'hF;
        for (int k = 0; k < 25; k++) begin
            bus3.wr_data_in = 32'h100 + 32'(k);
            check("ws_ready", {31'd0, bus3.ready_out}, {31'd0, (k % 5) == 0});
            check("ws_resp", {31'd0, bus3.resp_valid_out}, {31'd0, (k % 5) == 4});
            if ((k % 5) == 4) check("ws_err", {31'd0, bus3.err_out}, 32'd0);
            if (k == 0) check("ws_sseg", sseg3, 32'd0);
            else        check("ws_sseg", sseg3, 32'h100 + 32'(5 * ((k - 1) / 5)));
            @(negedge clk_in);
        end
        bus3.req_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
